muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage that owns the HI/LO registers.
- Produces the muldiv result that travels through the M and W pipeline registers to register-file writeback.
- Exposes a start/busy handshake so hazard control can stall dependent mfhi/mflo/mult/div instructions.
- The pipeline registers only read this result; this block is the producer.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update.
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue pulse for the op on op_i; valid for ops 1-4 (9-10 with MADD_EN).
- op_i  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU.
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- busy  output  1  computation in progress.
- stall_req  output  1  combinational: (busy | start) & (op_i != NONE); consumed by the hazard unit.
- result  output  32  combinational: HI when op_i=MFHI, LO when op_i=MFLO, else 0.
- hi_o  output  32  current HI register.
- lo_o  output  32  current LO register.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, cycle counter=0, operand/op latches cleared.
- States: IDLE and RUN.
- IDLE -> RUN: start=1 with op 1-4 at a clock edge.
  - Latch rs_data, rt_data and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- RUN: counter decrements by 1 each edge. At the edge where counter goes 1 -> 0:
  - write HI/LO;
  - set busy=0;
  - return to IDLE.
  - Net effect: HI/LO are visible exactly N edges after the start edge, and busy is high for N cycles.
- start while busy=1: ignored, no relatch. The hazard unit must hold the instruction (stall_req covers this).
- MTHI/MTLO while IDLE: HI or LO <= rs_data at the next edge. While busy they are ignored (stall_req keeps them held).
- MFHI/MFLO: no state change; result is combinational from the current HI/LO.
- Same-cycle read after completion: HI/LO registers update at the completion edge, so an MFHI in the following cycle sees the new value.
- MULT: signed 64-bit product; HI=[63:32], LO=[31:0].
- MULTU: same layout, unsigned product.
- DIV: LO=signed quotient truncated toward zero; HI=remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): the full DIV_CYCLES latency is still spent; HI and LO are left unchanged.
- Operands are used from the latched copies only; changes on rs_data/rt_data during RUN have no effect.
- Reset asserted mid-operation: immediate abort, IDLE, HI=LO=0; no partial write.
- An internal iterative or a single-cycle combinational datapath are both acceptable, provided the visible latency is exactly as specified.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined:
  - op 9 MADD: {HI,LO} += signed rs*rt.
  - op 10 MADDU: {HI,LO} += unsigned rs*rt.
  - Both use the 64-bit sum with wrap-around, MULT_CYCLES latency, and the HI/LO values at completion.
- Undefined: ops 9 and 10 are treated as NONE (no start, stall_req=0, no state change).

Test Plan:
- Reset low mid-run, then release -> busy=0, hi_o=lo_o=0 immediately and no late write.
- MULT rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI result=0xFFFFFFFF.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV cases, each after 10 busy cycles:
  - rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 with HI=LO=0x12345678 preloaded via MTHI/MTLO -> 10 busy cycles, HI/LO still 0x12345678.
- Second MULT start asserted during busy -> ignored, stall_req=1 throughout, only the first result is written.
- With MULDIV_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU rs=1, rt=1 -> HI=1, LO=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; start/busy handshake with fixed latency.
// Optional MADD/MADDU accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r, state_next_s;
  logic [7:0]  cnt_r;
  logic [3:0]  op_r;
  logic [31:0] a_r, b_r, hi_r, lo_r;
  logic        busy_r;
  logic        is_mul_s, is_div_s, issue_op_s, live_op_s;
  logic        accept_s, done_s, wr_s;
  logic [31:0] hi_next_s, lo_next_s;
  logic [63:0] prod_s, sdiv_s;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // Signed divide on magnitudes so MIN/-1 wraps to MIN; returns {remainder, quotient}.
  function automatic logic [63:0] sdiv64(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur;
    ua = a[31] ? (32'd0 - a) : a;
    ub = b[31] ? (32'd0 - b) : b;
    uq = ua / ub;
    ur = ua % ub;
    return {(a[31] ? (32'd0 - ur) : ur), ((a[31] ^ b[31]) ? (32'd0 - uq) : uq)};
  endfunction

  // Decode of the incoming op for issue and stall purposes.
  always_comb begin
    is_mul_s  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    is_div_s  = (op_i == OP_DIV) || (op_i == OP_DIVU);
`ifdef MULDIV_MADD_EN
    is_mul_s  = is_mul_s || (op_i == OP_MADD) || (op_i == OP_MADDU);
    live_op_s = (op_i != OP_NONE);
`else
    live_op_s = (op_i != OP_NONE) && (op_i != OP_MADD) && (op_i != OP_MADDU);
`endif
    issue_op_s = is_mul_s || is_div_s;
  end

  assign stall_req = (busy_r || start) && live_op_s;

  // Next-state and handshake control.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && issue_op_s) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 8'd1) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign prod_s = mul64(a_r, b_r, (op_r == OP_MULT) || (op_r == OP_MADD));
  assign sdiv_s = sdiv64(a_r, b_r);

  // Completion value for HI/LO from the latched operands; divide by zero writes nothing.
  always_comb begin
    wr_s      = 1'b0;
    hi_next_s = hi_r;
    lo_next_s = lo_r;
    case (op_r)
      OP_MULT, OP_MULTU: begin
        wr_s      = 1'b1;
        hi_next_s = prod_s[63:32];
        lo_next_s = prod_s[31:0];
      end
      OP_DIV: begin
        if (b_r != 32'd0) begin
          wr_s      = 1'b1;
          hi_next_s = sdiv_s[63:32];
          lo_next_s = sdiv_s[31:0];
        end else begin
          wr_s      = 1'b0;
        end
      end
      OP_DIVU: begin
        if (b_r != 32'd0) begin
          wr_s      = 1'b1;
          hi_next_s = a_r % b_r;
          lo_next_s = a_r / b_r;
        end else begin
          wr_s      = 1'b0;
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: begin
        wr_s                   = 1'b1;
        {hi_next_s, lo_next_s} = {hi_r, lo_r} + prod_s;
      end
`endif
      default: wr_s = 1'b0;
    endcase
  end

  // Control registers: state, countdown, operand latches and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      op_r    <= OP_NONE;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r   <= op_i;
        a_r    <= rs_data;
        b_r    <= rt_data;
        cnt_r  <= is_mul_s ? MULT_LOAD : DIV_LOAD;
        busy_r <= 1'b1;
      end else if (state_r == ST_RUN) begin
        cnt_r  <= cnt_r - 8'd1;
        busy_r <= !done_s;
      end
    end
  end

  // HI/LO registers: written at completion or by MTHI/MTLO while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (done_s) begin
      if (wr_s) begin
        hi_r <= hi_next_s;
        lo_r <= lo_next_s;
      end
    end else if (state_r == ST_IDLE) begin
      if (op_i == OP_MTHI) hi_r <= rs_data;
      if (op_i == OP_MTLO) lo_r <= rs_data;
    end
  end

  // Move-from read port follows the current HI/LO directly.
  always_comb begin
    case (op_i)
      OP_MFHI: result = hi_r;
      OP_MFLO: result = lo_r;
      default: result = 32'd0;
    endcase
  end

  assign busy = busy_r;
  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy, stall_req;
  logic [31:0] result, hi_o, lo_o;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  int          n_checks = 0;
  int          n_pass = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op_i(op_i),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .stall_req(stall_req),
    .result(result), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue an arithmetic op, follow it for its whole latency and update the model.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit extra);
    logic [63:0] acc;
    longint      sa, sb, q, r;
    logic [31:0] nh, nl;
    int          n;
    nh = hi_m; nl = lo_m; n = 5;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin acc = 64'(sa * sb); nh = acc[63:32]; nl = acc[31:0]; end
      OP_MULTU: begin acc = {32'h0, a} * {32'h0, b}; nh = acc[63:32]; nl = acc[31:0]; end
      OP_DIV: begin
        n = 10;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      OP_DIVU: begin
        n = 10;
        if (b != 32'd0) begin nl = a / b; nh = a % b; end
      end
      OP_MADD:  begin acc = {hi_m, lo_m} + 64'(sa * sb); nh = acc[63:32]; nl = acc[31:0]; end
      OP_MADDU: begin acc = {hi_m, lo_m} + {32'h0, a} * {32'h0, b}; nh = acc[63:32]; nl = acc[31:0]; end
      default: ;
    endcase
    @(negedge clk);
    start = 1'b1; op_i = op; rs_data = a; rt_data = b;
    #1 check("stall_on_issue", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    start = 1'b0; op_i = OP_NONE; rs_data = $urandom; rt_data = $urandom;
    for (int i = 0; i < n; i++) begin
      if (extra && i >= 1) begin
        start = 1'b1; op_i = OP_MULT; rs_data = $urandom; rt_data = $urandom;
        #1 check("stall_while_busy", {31'd0, stall_req}, 32'd1);
      end
      check("busy_during_run", {31'd0, busy}, 32'd1);
      if (i == n - 1) begin
        check("hi_held_before_done", hi_o, hi_m);
        check("lo_held_before_done", lo_o, lo_m);
      end
      @(negedge clk);
    end
    start = 1'b0; op_i = OP_NONE;
    hi_m = nh; lo_m = nl;
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("hi_after_done", hi_o, hi_m);
    check("lo_after_done", lo_o, lo_m);
  endtask

  task automatic mf_check();
    op_i = OP_MFHI;
    #1 check("mfhi_result", result, hi_m);
    check("mfhi_no_stall", {31'd0, stall_req}, 32'd0);
    op_i = OP_MFLO;
    #1 check("mflo_result", result, lo_m);
    op_i = OP_NONE;
    #1 check("none_result", result, 32'd0);
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    op_i = op; rs_data = v;
    @(negedge clk);
    op_i = OP_NONE; rs_data = $urandom;
    if (op == OP_MTHI) hi_m = v;
    else lo_m = v;
    check("mt_hi", hi_o, hi_m);
    check("mt_lo", lo_o, lo_m);
  endtask

  initial begin
    logic [31:0] a, b;
    int          sel;
    #1 check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_hi_const", hi_o, 32'hFFFFFFFF);
    check("mult_lo_const", lo_o, 32'hFFFFFFFA);
    mf_check();
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi_const", hi_o, 32'hFFFFFFFE);
    check("multu_lo_const", lo_o, 32'h00000001);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", lo_o, 32'hFFFFFFFD);
    check("div_neg_hi_const", hi_o, 32'hFFFFFFFF);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo_const", lo_o, 32'h80000000);
    check("div_ovf_hi_const", hi_o, 32'h00000000);
    mt_op(OP_MTHI, 32'h12345678);
    mt_op(OP_MTLO, 32'h12345678);
    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu_zero_hi_const", hi_o, 32'h12345678);
    check("divu_zero_lo_const", lo_o, 32'h12345678);
    run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 1'b1);
    check("busy_restart_lo_const", lo_o, 32'hFFFFFFEB);
    mf_check();

`ifdef MULDIV_MADD_EN
    mt_op(OP_MTHI, 32'd0);
    mt_op(OP_MTLO, 32'hFFFFFFFF);
    run_op(OP_MADDU, 32'd1, 32'd1, 1'b0);
    check("maddu_hi_const", hi_o, 32'd1);
    check("maddu_lo_const", lo_o, 32'd0);
`else
    @(negedge clk);
    start = 1'b1; op_i = OP_MADD; rs_data = 32'd3; rt_data = 32'd4;
    #1 check("madd_off_no_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0; op_i = OP_NONE;
    check("madd_off_no_busy", {31'd0, busy}, 32'd0);
    check("madd_off_hi", hi_o, hi_m);
    check("madd_off_lo", lo_o, lo_m);
`endif

    for (int k = 0; k < 30; k++) begin
`ifdef MULDIV_MADD_EN
      sel = $urandom_range(0, 7);
`else
      sel = $urandom_range(0, 5);
`endif
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 9);
        default: ;
      endcase
      case (sel)
        0: run_op(OP_MULT, a, b, 1'b0);
        1: run_op(OP_MULTU, a, b, 1'b0);
        2: run_op(OP_DIV, a, b, 1'b0);
        3: run_op(OP_DIVU, a, b, 1'b0);
        4: mt_op(OP_MTHI, a);
        5: mt_op(OP_MTLO, a);
        6: run_op(OP_MADD, a, b, 1'b0);
        default: run_op(OP_MADDU, a, b, 1'b0);
      endcase
      mf_check();
    end

    mt_op(OP_MTHI, 32'hA5A5A5A5);
    @(negedge clk);
    start = 1'b1; op_i = OP_DIV; rs_data = 32'd1000; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; op_i = OP_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1 check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi_o, 32'd0);
    check("abort_lo", lo_o, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_late_busy", {31'd0, busy}, 32'd0);
    check("abort_no_late_hi", hi_o, hi_m);
    check("abort_no_late_lo", lo_o, lo_m);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
